// File: rtl/logic_unit_arbiter_if.sv
// Bundle between the requesting clients, the external 1-bit logic unit and the arbiter.
// The arbiter connects through the slave modport; the client/logic-unit side uses master.
interface logic_unit_arbiter_if #(
   parameter int NREQ = 4,
   parameter int W    = 8
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]   req;
   logic [2*NREQ-1:0] op_key;
   logic [W*NREQ-1:0] op_a;
   logic [W*NREQ-1:0] op_b;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic              done;
   logic [IW-1:0]     done_id;
   logic [W-1:0]      result;
   logic              err;
   logic              lu_x;
   logic              lu_y;
   logic [1:0]        lu_key;
   logic              lu_r;

   modport master (
      output req, op_key, op_a, op_b, lu_r,
      input  gnt, busy, done, done_id, result, err, lu_x, lu_y, lu_key
   );

   modport slave (
      input  req, op_key, op_a, op_b, lu_r,
      output gnt, busy, done, done_id, result, err, lu_x, lu_y, lu_key
   );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bit-serial OR/NOR/XOR/XNOR unit among NREQ requesters.
// Optional lu_r self-check enabled by defining LU_ARB_CHECK_EN (err tied low otherwise).
//
// state  | meaning
// S_IDLE | waiting for any req; winner's operands latched on the grant edge
// S_RUN  | W cycles driving A[idx]/B[idx]/KEY to the unit, collecting lu_r
// S_DONE | one cycle with done=1; rr pointer advances past the winner on exit
module logic_unit_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8
) (
   input logic                 clk,
   input logic                 reset,
   logic_unit_arbiter_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int XW = (W > 1) ? $clog2(W) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   winner;
   logic [IW-1:0]   pick;
   logic            pick_ok;
   logic [XW-1:0]   idx;
   logic [W-1:0]    a_sh;
   logic [W-1:0]    b_sh;
   logic [1:0]      key_sh;
   logic [W-1:0]    res_sh;
   logic [W-1:0]    res_next;
   logic [W-1:0]    result_q;
   logic [IW-1:0]   done_id_q;
   logic [NREQ-1:0] win_onehot;
   logic            run;

   // Scan downward so the requester closest to ptr (lowest offset) is assigned last.
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req[(int'(ptr) + k) % NREQ]) begin
            pick    = IW'((int'(ptr) + k) % NREQ);
            pick_ok = 1'b1;
         end
      end
   end

   always_comb begin
      res_next      = res_sh;
      res_next[idx] = bus.lu_r;
   end

   always_comb begin
      win_onehot         = '0;
      win_onehot[winner] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         ptr       <= '0;
         winner    <= '0;
         idx       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         key_sh    <= 2'b00;
         res_sh    <= '0;
         result_q  <= '0;
         done_id_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_ok) begin
                  winner <= pick;
                  a_sh   <= bus.op_a[W*pick +: W];
                  b_sh   <= bus.op_b[W*pick +: W];
                  key_sh <= bus.op_key[2*pick +: 2];
                  idx    <= '0;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               res_sh <= res_next;
               if (idx == XW'(W - 1)) begin
                  result_q  <= res_next;
                  done_id_q <= winner;
                  idx       <= '0;
                  state     <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               ptr   <= IW'((int'(winner) + 1) % NREQ);
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign run         = (state == S_RUN);
   assign bus.busy    = (state != S_IDLE);
   assign bus.done    = (state == S_DONE);
   assign bus.gnt     = (run && idx == '0) ? win_onehot : '0;
   assign bus.lu_x    = run ? a_sh[idx] : 1'b0;
   assign bus.lu_y    = run ? b_sh[idx] : 1'b0;
   assign bus.lu_key  = run ? key_sh : 2'b00;
   assign bus.result  = result_q;
   assign bus.done_id = done_id_q;

`ifdef LU_ARB_CHECK_EN
   logic err_q;
   logic model_r;

   always_comb begin
      case (key_sh)
         2'b00:   model_r = a_sh[idx] | b_sh[idx];
         2'b01:   model_r = ~(a_sh[idx] | b_sh[idx]);
         2'b10:   model_r = a_sh[idx] ^ b_sh[idx];
         default: model_r = ~(a_sh[idx] ^ b_sh[idx]);
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err_q <= 1'b0;
      else if (run && bus.lu_r != model_r)
         err_q <= 1'b1;
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomized self-checking bench for logic_unit_arbiter (NREQ=4, W=8) against a
// transaction-level model: round-robin pick, whole-word logic result, fixed timing.
module tb_logic_unit_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic lu_force = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   int   m_ptr = 0;
   logic m_err = 1'b0;

   logic_unit_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   logic_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic lu_bit(input logic [1:0] k, input logic x, input logic y);
      case (k)
         2'b00:   return x | y;
         2'b01:   return ~(x | y);
         2'b10:   return x ^ y;
         default: return ~(x ^ y);
      endcase
   endfunction

   assign bus.lu_r = lu_force ? 1'b0 : lu_bit(bus.lu_key, bus.lu_x, bus.lu_y);

   function automatic logic [7:0] lu_word(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b);
      case (k)
         2'b00:   return a | b;
         2'b01:   return ~(a | b);
         2'b10:   return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_ops(input int i, input logic [1:0] k, input logic [7:0] a, input logic [7:0] b);
      bus.op_key[2*i +: 2] = k;
      bus.op_a[8*i +: 8]   = a;
      bus.op_b[8*i +: 8]   = b;
   endtask

   // One full transaction from the current req pattern; returns at the done cycle.
   task automatic run_txn(input bit mutate, input bit chk_lat);
      int cyc;
      int w;
      logic [7:0] a, b, exp_r;
      logic [1:0] k;
      w = rr_pick(bus.req, m_ptr);
      if (w < 0) begin
         chk("txn_req", 32'(bus.req), 32'hFFFF_FFFF);
         return;
      end
      a = bus.op_a[8*w +: 8];
      b = bus.op_b[8*w +: 8];
      k = bus.op_key[2*w +: 2];
      exp_r = lu_force ? 8'h00 : lu_word(k, a, b);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.gnt == '0 && cyc < 40);
      chk("gnt", 32'(bus.gnt), 32'(1) << w);
      if (bus.gnt == '0) return;
      if (chk_lat) chk("gnt_latency", 32'(cyc), 32'd1);
      if (mutate) bus.op_a[8*w +: 8] = ~a;
      for (int i = 0; i < W; i++) begin
         if (i > 0) begin
            @(negedge clk);
            chk("gnt_run", 32'(bus.gnt), 32'd0);
         end
         chk("busy_run", 32'(bus.busy), 32'd1);
         chk("done_run", 32'(bus.done), 32'd0);
         chk("lu_x", 32'(bus.lu_x), 32'(a[i]));
         chk("lu_y", 32'(bus.lu_y), 32'(b[i]));
         chk("lu_key", 32'(bus.lu_key), 32'(k));
      end
      @(negedge clk);
      chk("done", 32'(bus.done), 32'd1);
      chk("busy_done", 32'(bus.busy), 32'd1);
      chk("result", 32'(bus.result), 32'(exp_r));
      chk("done_id", 32'(bus.done_id), 32'(w));
      chk("lu_key_idle", 32'(bus.lu_key), 32'd0);
      chk("lu_x_idle", 32'(bus.lu_x), 32'd0);
      chk("err", 32'(bus.err), 32'(m_err));
      m_ptr = (w + 1) % NREQ;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_ptr = 0;
      m_err = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.req    = '0;
      bus.op_key = '0;
      bus.op_a   = '0;
      bus.op_b   = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_done_id", 32'(bus.done_id), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_lu", {29'd0, bus.lu_x, bus.lu_key}, 32'd0);
      reset = 1'b0;

      // Directed: basic OR with latency check, then remaining keys via requester 0.
      set_ops(0, 2'b00, 8'hF0, 8'h0F);
      bus.req = 4'b0001;
      run_txn(1'b0, 1'b1);
      chk("res_or", 32'(bus.result), 32'h0000_00FF);
      bus.req = '0;
      set_ops(0, 2'b01, 8'h00, 8'h01);
      bus.req = 4'b0001;
      run_txn(1'b0, 1'b0);
      chk("res_nor", 32'(bus.result), 32'h0000_00FE);
      bus.req = '0;
      set_ops(0, 2'b10, 8'h3C, 8'h0F);
      bus.req = 4'b0001;
      run_txn(1'b0, 1'b0);
      chk("res_xor", 32'(bus.result), 32'h0000_0033);
      bus.req = '0;
      set_ops(0, 2'b11, 8'hAA, 8'hAA);
      bus.req = 4'b0001;
      run_txn(1'b0, 1'b0);
      chk("res_xnor", 32'(bus.result), 32'h0000_00FF);
      bus.req = '0;

      // All four held from reset: strict rotation, then wrap back to 0.
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++)
         set_ops(i, 2'($urandom), 8'($urandom), 8'($urandom));
      bus.req = 4'b1111;
      @(negedge clk);
      reset = 1'b0;
      m_ptr = 0;
      for (int i = 0; i < NREQ; i++) begin
         run_txn(1'b0, 1'b0);
         chk("rot_id", 32'(bus.done_id), 32'(i));
      end
      bus.req = 4'b1001;
      run_txn(1'b0, 1'b0);
      chk("wrap_id", 32'(bus.done_id), 32'd0);
      bus.req = '0;

      // Reset in the middle of RUN.
      set_ops(0, 2'b00, 8'h5A, 8'h81);
      bus.req = 4'b0001;
      begin
         int cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (bus.gnt == '0 && cyc < 40);
         chk("mid_gnt", 32'(bus.gnt), 32'd1);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_gnt", 32'(bus.gnt), 32'd0);
      chk("abort_result", 32'(bus.result), 32'd0);
      chk("abort_lu", {29'd0, bus.lu_x, bus.lu_key}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      m_ptr = 0;
      run_txn(1'b0, 1'b0);
      bus.req = '0;

      // Operand change after grant is ignored; a held competitor waits for done.
      set_ops(0, 2'b10, 8'h96, 8'h3C);
      set_ops(1, 2'b00, 8'h12, 8'h40);
      bus.req = 4'b0011;
      run_txn(1'b1, 1'b0);
      run_txn(1'b0, 1'b0);
      bus.req = '0;

      // Broken logic unit: err behaviour depends on the checker build.
      lu_force = 1'b1;
      set_ops(0, 2'b00, 8'h01, 8'h00);
      bus.req = 4'b0001;
`ifdef LU_ARB_CHECK_EN
      m_err = 1'b1;
`endif
      run_txn(1'b0, 1'b0);
      lu_force = 1'b0;
      run_txn(1'b0, 1'b0);
      bus.req = '0;
      do_reset();
      chk("err_cleared", 32'(bus.err), 32'd0);

      // Randomized traffic.
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < NREQ; i++)
            set_ops(i, 2'($urandom), 8'($urandom), 8'($urandom));
         bus.req = 4'($urandom_range(1, 15));
         run_txn(1'($urandom), 1'b0);
      end
      bus.req = '0;
      @(negedge clk);
      chk("final_busy", 32'(bus.busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
